traffic_light_controller: RTL and testbench

Two-way intersection controller with pedestrian request, clocked by `CLK_5_MHZ` and paced by the slow `CLK_2_HZ` output of the clock divider. `CLK_2_HZ` is a data input here, not a clock. It is synchronized and edge-detected into a one-cycle tick, and all phase durations are counted in ticks. The block drives the north-south and east-west lamp sets plus a walk lamp on the board's LEDs.

---
 rtl/traffic_light_controller.sv | 173 +++++++++++++++++
 tb/tb_traffic_light_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Two-way intersection controller with pedestrian walk phase, paced by ticks derived from CLK_2_HZ.
// Latency: CLK_2_HZ rise -> tick after 3 cycles -> lamps after 4; ped_btn rise -> ped_pending after 3.
// Backpressure: none; a free-running Moore FSM that samples its inputs every cycle and never stalls.
module traffic_light_controller #(
  parameter int unsigned GREEN_TICKS     = 10,
  parameter int unsigned MIN_GREEN_TICKS = 4,
  parameter int unsigned YELLOW_TICKS    = 3,
  parameter int unsigned ALL_RED_TICKS   = 1,
  parameter int unsigned WALK_TICKS      = 6
) (
  input  logic       CLK_5_MHZ,
  input  logic       reset,
  input  logic       CLK_2_HZ,
  input  logic       ped_btn,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    ILLEGAL   = 3'd7
  } state_t;

  // Last tick_cnt value of each phase (duration minus one).
  localparam logic [7:0] GREEN_LAST     = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] MIN_GREEN_LAST = 8'(MIN_GREEN_TICKS - 1);
  localparam logic [7:0] YELLOW_LAST    = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] ALL_RED_LAST   = 8'(ALL_RED_TICKS - 1);
  localparam logic [7:0] WALK_LAST      = 8'(WALK_TICKS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] tick_cnt;
  logic [7:0] next_cnt;
  logic [7:0] phase_last;
  logic       is_green;
  logic       phase_done;

  logic       slow_s1;
  logic       slow_s2;
  logic       slow_s3;
  logic       tick;

  logic       btn_s1;
  logic       btn_s2;
  logic       btn_s3;
  logic       btn_edge;

  assign state = cur_state;

  function automatic logic [2:0] ns_decode(input state_t s);
    case (s)
      NS_GREEN:  return LAMP_GREEN;
      NS_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_decode(input state_t s);
    case (s)
      EW_GREEN:  return LAMP_GREEN;
      EW_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  // Synchronize CLK_2_HZ and register its rising edge as a one-cycle tick.
  always_ff @(posedge CLK_5_MHZ) begin
    if (reset) begin
      slow_s1 <= 1'b0;
      slow_s2 <= 1'b0;
      slow_s3 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      slow_s1 <= CLK_2_HZ;
      slow_s2 <= slow_s1;
      slow_s3 <= slow_s2;
      tick    <= slow_s2 & ~slow_s3;
    end
  end

  // Synchronize the push-button; its rising edge is used combinationally.
  always_ff @(posedge CLK_5_MHZ) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= ped_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_edge = btn_s2 & ~btn_s3;

  // Phase length selection, green cut-short rule and successor state.
  always_comb begin
    next_state = cur_state;
    next_cnt   = tick_cnt;
    phase_last = ALL_RED_LAST;
    case (cur_state)
      NS_GREEN, EW_GREEN:   phase_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: phase_last = YELLOW_LAST;
      ALL_RED_A, ALL_RED_B: phase_last = ALL_RED_LAST;
      PED_WALK:             phase_last = WALK_LAST;
      default:              phase_last = ALL_RED_LAST;
    endcase
    is_green   = (cur_state == NS_GREEN) || (cur_state == EW_GREEN);
    phase_done = (tick_cnt == phase_last) ||
                 (is_green && ped_pending && (tick_cnt >= MIN_GREEN_LAST));

    if (cur_state == ILLEGAL) begin
      // Unreachable code recovers to the clearance phase without waiting for a tick.
      next_state = ALL_RED_B;
      next_cnt   = 8'd0;
    end else if (tick) begin
      if (phase_done) begin
        next_cnt = 8'd0;
        case (cur_state)
          NS_GREEN:  next_state = NS_YELLOW;
          NS_YELLOW: next_state = ALL_RED_A;
          ALL_RED_A: next_state = EW_GREEN;
          EW_GREEN:  next_state = EW_YELLOW;
          EW_YELLOW: next_state = ALL_RED_B;
          ALL_RED_B: next_state = ped_pending ? PED_WALK : NS_GREEN;
          PED_WALK:  next_state = NS_GREEN;
          default:   next_state = ALL_RED_B;
        endcase
      end else begin
        next_cnt = tick_cnt + 8'd1;
      end
    end
  end

  // State, phase counter, pedestrian latch and lamps registered together so lamps track the state.
  always_ff @(posedge CLK_5_MHZ) begin
    if (reset) begin
      cur_state   <= ALL_RED_B;
      tick_cnt    <= 8'd0;
      ped_pending <= 1'b0;
      ns_light    <= LAMP_RED;
      ew_light    <= LAMP_RED;
      walk        <= 1'b0;
    end else begin
      cur_state <= next_state;
      tick_cnt  <= next_cnt;
      // Entering the walk phase serves the request; presses during the walk are dropped.
      if ((next_state == PED_WALK) && (cur_state != PED_WALK)) begin
        ped_pending <= 1'b0;
      end else if (btn_edge && (cur_state != PED_WALK)) begin
        ped_pending <= 1'b1;
      end
      ns_light <= ns_decode(next_state);
      ew_light <= ew_decode(next_state);
      walk     <= (next_state == PED_WALK);
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: table vectors, hand sequences and random button presses
// checked against a per-tick phase model of the intersection rules.
module tb_traffic_light_controller;

  logic       CLK_5_MHZ = 1'b0;
  logic       reset;
  logic       CLK_2_HZ;
  logic       ped_btn;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state;

  traffic_light_controller dut (
    .CLK_5_MHZ  (CLK_5_MHZ),
    .reset      (reset),
    .CLK_2_HZ   (CLK_2_HZ),
    .ped_btn    (ped_btn),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .ped_pending(ped_pending),
    .state      (state)
  );

  always #5 CLK_5_MHZ = ~CLK_5_MHZ;

  int n_tests = 0;
  int n_fail  = 0;

  // Phase model: phases numbered in cycle order 0..6 (NS green .. walk) with their lengths in ticks.
  int dur_of [7] = '{10, 3, 1, 10, 3, 1, 6};
  localparam int MIN_GREEN = 4;
  int m_phase;
  int m_elapsed;
  bit m_pend;

  typedef struct {
    bit press;
    int st;
    bit pend;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_ns(input int ph);
    return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic int exp_ew(input int ph);
    return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_reset();
    m_phase   = 5;
    m_elapsed = 0;
    m_pend    = 1'b0;
  endtask

  task automatic model_tick();
    bit green;
    bit leave;
    int nxt;
    m_elapsed++;
    green = (m_phase == 0) || (m_phase == 3);
    leave = (m_elapsed >= dur_of[m_phase]) || (green && m_pend && m_elapsed >= MIN_GREEN);
    if (leave) begin
      if (m_phase == 5) nxt = m_pend ? 6 : 0;
      else if (m_phase == 6) nxt = 0;
      else nxt = m_phase + 1;
      if (nxt == 6) m_pend = 1'b0;
      m_phase   = nxt;
      m_elapsed = 0;
    end
  endtask

  task automatic model_press();
    if (m_phase != 6) m_pend = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, int'(state), m_phase);
    check({tag, ".ns"}, int'(ns_light), exp_ns(m_phase));
    check({tag, ".ew"}, int'(ew_light), exp_ew(m_phase));
    check({tag, ".walk"}, int'(walk), (m_phase == 6) ? 1 : 0);
    check({tag, ".pend"}, int'(ped_pending), int'(m_pend));
    check({tag, ".one_dir"}, int'((ns_light != 3'b100) && (ew_light != 3'b100)), 0);
  endtask

  // One 8-cycle period of CLK_2_HZ; an optional button press starts on its falling half.
  task automatic slow_cycle(input bit press, input string tag);
    int pre;
    @(posedge CLK_5_MHZ); #1;
    CLK_2_HZ = 1'b1;
    pre = m_phase;
    model_tick();
    repeat (3) @(posedge CLK_5_MHZ);
    @(negedge CLK_5_MHZ);
    check({tag, ".hold"}, int'(state), pre);
    @(posedge CLK_5_MHZ); #1;
    CLK_2_HZ = 1'b0;
    ped_btn  = press;
    @(negedge CLK_5_MHZ);
    check_model({tag, ".tick"});
    if (press) model_press();
    repeat (2) @(posedge CLK_5_MHZ); #1;
    ped_btn = 1'b0;
    @(posedge CLK_5_MHZ);
    @(negedge CLK_5_MHZ);
    check_model({tag, ".btn"});
  endtask

  // Same cadence as slow_cycle, but counts cycles from the CLK_2_HZ rise to the lamp change.
  task automatic lat_cycle();
    logic [5:0] old;
    int lat;
    old = {ns_light, ew_light};
    lat = -1;
    @(posedge CLK_5_MHZ); #1;
    CLK_2_HZ = 1'b1;
    model_tick();
    for (int i = 1; i <= 7; i++) begin
      @(posedge CLK_5_MHZ); #1;
      if (i == 4) CLK_2_HZ = 1'b0;
      if (lat < 0 && {ns_light, ew_light} != old) lat = i;
    end
    check("lat.rise_to_lamp", lat, 4);
    @(negedge CLK_5_MHZ);
    check_model("lat");
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK_5_MHZ); #1;
    reset    = 1'b1;
    CLK_2_HZ = 1'b0;
    ped_btn  = 1'b0;
    repeat (2) @(posedge CLK_5_MHZ); #1;
    reset = 1'b0;
    model_reset();
    @(negedge CLK_5_MHZ);
    check({tag, ".state"}, int'(state), 5);
    check({tag, ".pend"}, int'(ped_pending), 0);
    check({tag, ".ns"}, int'(ns_light), 3'b100);
    check({tag, ".ew"}, int'(ew_light), 3'b100);
    check({tag, ".walk"}, int'(walk), 0);
  endtask

  task automatic add_vec(input bit p, input int s, input bit d, input int rep);
    vec_t v;
    v.press = p;
    v.st    = s;
    v.pend  = d;
    for (int k = 0; k < rep; k++) vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    CLK_2_HZ = 1'b0;
    ped_btn  = 1'b0;
    model_reset();

    // Expected state / pending after each slow period, starting from reset (ALL_RED_B).
    // Press at NS green tick 1 cuts both greens to 4 ticks, then walk; a press during walk is dropped.
    add_vec(0, 0, 0, 1);
    add_vec(1, 0, 1, 1);
    add_vec(0, 0, 1, 2);
    add_vec(0, 1, 1, 3);
    add_vec(0, 2, 1, 1);
    add_vec(0, 3, 1, 4);
    add_vec(0, 4, 1, 3);
    add_vec(0, 5, 1, 1);
    add_vec(0, 6, 0, 2);
    add_vec(1, 6, 0, 1);
    add_vec(0, 6, 0, 3);
    add_vec(0, 0, 0, 10);
    add_vec(0, 1, 0, 1);

    // Power-on reset held for two cycles.
    repeat (2) @(posedge CLK_5_MHZ); #1;
    reset = 1'b0;
    @(negedge CLK_5_MHZ);
    check("rst0.state", int'(state), 5);
    check("rst0.ns", int'(ns_light), 3'b100);
    check("rst0.ew", int'(ew_light), 3'b100);
    check("rst0.walk", int'(walk), 0);
    check("rst0.pend", int'(ped_pending), 0);

    // First tick leaves the all-red phase; measures rise-to-lamp latency at that boundary.
    lat_cycle();
    check("first_tick.ns_green", int'(ns_light), 3'b001);

    // Free run with no button: two full rounds.
    for (int i = 0; i < 60; i++) slow_cycle(1'b0, "free");

    // Table-driven pedestrian sequence.
    do_reset("rst1");
    for (int i = 0; i < vecs.size(); i++) begin
      slow_cycle(vecs[i].press, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.state_v", i), int'(state), vecs[i].st);
      check($sformatf("tbl%0d.pend_v", i), int'(ped_pending), int'(vecs[i].pend));
      check($sformatf("tbl%0d.ns_v", i), int'(ns_light), exp_ns(vecs[i].st));
      check($sformatf("tbl%0d.ew_v", i), int'(ew_light), exp_ew(vecs[i].st));
      check($sformatf("tbl%0d.walk_v", i), int'(walk), (vecs[i].st == 6) ? 1 : 0);
    end

    // Reset during EW yellow with a pending request: the request must not survive.
    slow_cycle(1'b1, "t5");
    for (int i = 0; i < 40 && m_phase != 4; i++) slow_cycle(1'b0, "t5");
    check("t5.in_ew_yellow", int'(state), 4);
    check("t5.pend_before", int'(ped_pending), 1);
    do_reset("t5.rst");
    slow_cycle(1'b0, "t5.after");
    check("t5.no_walk", int'(state), 0);

    // Random button presses against the phase model.
    for (int i = 0; i < 300; i++) begin
      slow_cycle(($urandom_range(5, 0) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
